// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data memory between the core
// (fixed priority) and the host port, with starvation-forced host cycles.
module data_mem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_ce_i,
  input  logic        core_we_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic [31:0] core_rdata_o,
  output logic        core_stall_o,
  input  logic        host_req_i,
  input  logic        host_we_i,
  input  logic [31:0] host_addr_i,
  input  logic [31:0] host_wdata_i,
  output logic        host_gnt_o,
  output logic        host_rvalid_o,
  output logic [31:0] host_rdata_o,
  output logic        mem_ce_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } st_t;

  st_t              r_st;
  st_t              w_st_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_rvalid;
  logic [31:0]      r_rdata;
  logic             w_core_sel;
  logic             w_host_sel;
  logic             w_host_rd;

  always_comb begin
    w_core_sel = 1'b0;
    w_host_sel = 1'b0;
    unique case (r_st)
      ST_FORCE: w_host_sel = host_req_i;
      default: begin
        w_core_sel = core_ce_i;
        w_host_sel = !core_ce_i && host_req_i;
      end
    endcase
  end

  // Enables are gated by reset so no write can land while rst is low.
  always_comb begin
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = core_addr_i;
    mem_wdata_o = core_wdata_i;
    host_gnt_o  = 1'b0;
    unique case (1'b1)
      w_host_sel: begin
        mem_ce_o    = rst;
        mem_we_o    = rst && host_we_i;
        mem_addr_o  = host_addr_i;
        mem_wdata_o = host_wdata_i;
        host_gnt_o  = rst;
      end
      w_core_sel: begin
        mem_ce_o = rst;
        mem_we_o = rst && core_we_i;
      end
      default: ;
    endcase
  end

  assign core_rdata_o  = mem_rdata_i;
  assign core_stall_o  = (r_st == ST_FORCE);
  assign host_rvalid_o = r_rvalid;
  assign host_rdata_o  = r_rdata;
  assign w_host_rd     = host_gnt_o && !host_we_i;

  always_comb begin
    w_cnt_nxt = '0;
    w_st_nxt  = ST_NORMAL;
    if (r_st == ST_NORMAL) begin
      if (host_req_i && !host_gnt_o)
        w_cnt_nxt = (r_cnt == LIM) ? LIM : r_cnt + CNT_W'(1);
      if (w_cnt_nxt == LIM)
        w_st_nxt = ST_FORCE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_st     <= ST_NORMAL;
      r_cnt    <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_st     <= w_st_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rvalid <= w_host_rd;
      if (w_host_rd)
        r_rdata <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed vectors against a behavioural data_mem,
// covering core-only, host-idle, starvation, withdraw and reset cases.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_ce_i;
  logic        core_we_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wdata_i;
  logic [31:0] core_rdata_o;
  logic        core_stall_o;
  logic        host_req_i;
  logic        host_we_i;
  logic [31:0] host_addr_i;
  logic [31:0] host_wdata_i;
  logic        host_gnt_o;
  logic        host_rvalid_o;
  logic [31:0] host_rdata_o;
  logic        mem_ce_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  logic [31:0] mem [0:63];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign mem_rdata_i = mem[mem_addr_o[7:2]];

  always @(posedge clk)
    if (mem_ce_o && mem_we_o)
      mem[mem_addr_o[7:2]] <= mem_wdata_o;

  data_mem_arbiter #(
    .STARVE_LIMIT(8),
    .CNT_W       (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .core_ce_i    (core_ce_i),
    .core_we_i    (core_we_i),
    .core_addr_i  (core_addr_i),
    .core_wdata_i (core_wdata_i),
    .core_rdata_o (core_rdata_o),
    .core_stall_o (core_stall_o),
    .host_req_i   (host_req_i),
    .host_we_i    (host_we_i),
    .host_addr_i  (host_addr_i),
    .host_wdata_i (host_wdata_i),
    .host_gnt_o   (host_gnt_o),
    .host_rvalid_o(host_rvalid_o),
    .host_rdata_o (host_rdata_o),
    .mem_ce_o     (mem_ce_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_set(input logic ce, input logic we,
                          input logic [31:0] a, input logic [31:0] d);
    core_ce_i    = ce;
    core_we_i    = we;
    core_addr_i  = a;
    core_wdata_i = d;
  endtask

  task automatic host_set(input logic req, input logic we,
                          input logic [31:0] a, input logic [31:0] d);
    host_req_i   = req;
    host_we_i    = we;
    host_addr_i  = a;
    host_wdata_i = d;
  endtask

  // Preload through the host port with the core idle.
  task automatic host_wr(input logic [31:0] a, input logic [31:0] d);
    host_set(1'b1, 1'b1, a, d);
    tick();
    host_set(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    core_set(1'b0, 1'b0, 32'h0, 32'h0);
    host_set(1'b1, 1'b1, 32'h40, 32'h0000_0BAD);
    #1;
    chk("rst_gnt", {31'b0, host_gnt_o}, 32'd0);
    chk("rst_we", {31'b0, mem_we_o}, 32'd0);
    tick();
    tick();
    chk("rst_stall", {31'b0, core_stall_o}, 32'd0);
    chk("rst_rvalid", {31'b0, host_rvalid_o}, 32'd0);
    chk("rst_rdata", host_rdata_o, 32'h0);
    host_set(1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    tick();

    // core only
    core_set(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    host_set(1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    chk("c_wr_we", {31'b0, mem_we_o}, 32'd1);
    chk("c_wr_gnt", {31'b0, host_gnt_o}, 32'd0);
    chk("c_wr_stall", {31'b0, core_stall_o}, 32'd0);
    tick();
    host_set(1'b0, 1'b0, 32'h0, 32'h0);
    core_set(1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    chk("c_rd_data", core_rdata_o, 32'hDEAD_BEEF);
    chk("c_rd_stall", {31'b0, core_stall_o}, 32'd0);
    tick();
    core_set(1'b0, 1'b0, 32'h0, 32'h0);

    // host with core idle
    host_set(1'b1, 1'b1, 32'h20, 32'h1234_5678);
    #1;
    chk("h_wr_gnt", {31'b0, host_gnt_o}, 32'd1);
    chk("h_wr_addr", mem_addr_o, 32'h20);
    tick();
    chk("h_wr_rvalid", {31'b0, host_rvalid_o}, 32'd0);
    host_set(1'b1, 1'b0, 32'h20, 32'h0);
    #1;
    chk("h_rd_gnt", {31'b0, host_gnt_o}, 32'd1);
    tick();
    host_set(1'b0, 1'b0, 32'h0, 32'h0);
    chk("h_rd_rvalid", {31'b0, host_rvalid_o}, 32'd1);
    chk("h_rd_data", host_rdata_o, 32'h1234_5678);
    tick();
    chk("h_rd_pulse", {31'b0, host_rvalid_o}, 32'd0);
    chk("h_rd_hold", host_rdata_o, 32'h1234_5678);

    host_wr(32'h30, 32'hCAFE_F00D);
    host_wr(32'h50, 32'h55AA_55AA);
    host_wr(32'h00, 32'hA0A0_A0A0);
    host_wr(32'h04, 32'hA1A1_A1A1);
    host_wr(32'h08, 32'hA2A2_A2A2);

    // starvation
    core_set(1'b1, 1'b0, 32'h10, 32'h0);
    host_set(1'b1, 1'b0, 32'h30, 32'h0);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("sv_gnt%0d", i), {31'b0, host_gnt_o}, 32'd0);
      chk($sformatf("sv_stl%0d", i), {31'b0, core_stall_o}, 32'd0);
      tick();
    end
    chk("sv_cnt", 32'(dut.r_cnt), 32'd8);
    #1;
    chk("sv_f_stall", {31'b0, core_stall_o}, 32'd1);
    chk("sv_f_gnt", {31'b0, host_gnt_o}, 32'd1);
    chk("sv_f_addr", mem_addr_o, 32'h30);
    tick();
    host_set(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("sv_rvalid", {31'b0, host_rvalid_o}, 32'd1);
    chk("sv_rdata", host_rdata_o, 32'hCAFE_F00D);
    chk("sv_stall0", {31'b0, core_stall_o}, 32'd0);
    chk("sv_cnt0", 32'(dut.r_cnt), 32'd0);
    chk("sv_core", core_rdata_o, 32'hDEAD_BEEF);
    tick();

    // host request withdrawn
    host_set(1'b1, 1'b0, 32'h30, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    chk("wd_cnt5", 32'(dut.r_cnt), 32'd5);
    host_set(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("wd_cnt0", 32'(dut.r_cnt), 32'd0);
    host_set(1'b1, 1'b0, 32'h30, 32'h0);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("wd_stl%0d", i), {31'b0, core_stall_o}, 32'd0);
      chk($sformatf("wd_gnt%0d", i), {31'b0, host_gnt_o}, 32'd0);
      tick();
    end
    chk("wd_f_stall", {31'b0, core_stall_o}, 32'd1);
    chk("wd_f_gnt", {31'b0, host_gnt_o}, 32'd1);
    tick();
    host_set(1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // reset during FORCE
    host_set(1'b1, 1'b1, 32'h50, 32'h0BAD_F00D);
    for (int i = 0; i < 8; i++) tick();
    chk("rf_stall", {31'b0, core_stall_o}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rf_we", {31'b0, mem_we_o}, 32'd0);
    chk("rf_ce", {31'b0, mem_ce_o}, 32'd0);
    chk("rf_gnt", {31'b0, host_gnt_o}, 32'd0);
    tick();
    rst = 1'b1;
    host_set(1'b0, 1'b0, 32'h0, 32'h0);
    core_set(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("rf_stall0", {31'b0, core_stall_o}, 32'd0);
    chk("rf_rvalid", {31'b0, host_rvalid_o}, 32'd0);
    chk("rf_mem", mem[20], 32'h55AA_55AA);
    tick();

    // back-to-back host reads
    host_set(1'b1, 1'b0, 32'h00, 32'h0);
    #1;
    chk("bb_gnt0", {31'b0, host_gnt_o}, 32'd1);
    tick();
    host_set(1'b1, 1'b0, 32'h04, 32'h0);
    chk("bb_v0", {31'b0, host_rvalid_o}, 32'd1);
    chk("bb_d0", host_rdata_o, 32'hA0A0_A0A0);
    tick();
    host_set(1'b1, 1'b0, 32'h08, 32'h0);
    chk("bb_v1", {31'b0, host_rvalid_o}, 32'd1);
    chk("bb_d1", host_rdata_o, 32'hA1A1_A1A1);
    tick();
    host_set(1'b0, 1'b0, 32'h0, 32'h0);
    chk("bb_v2", {31'b0, host_rvalid_o}, 32'd1);
    chk("bb_d2", host_rdata_o, 32'hA2A2_A2A2);
    tick();
    chk("bb_end", {31'b0, host_rvalid_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-master arbiter that shares the single-port data memory between the RISC-V core's data port and a host/debug port, used for preload, readback and DMA. The block sits between `riscv` and `data_mem` in the SoC.
- The core has fixed priority.
- The host is served in cycles where the core does not access memory.
- A starvation counter guarantees host progress by stalling the core for one cycle.

## Interface
Parameters:
- `STARVE_LIMIT`, 8: consecutive cycles with host denied before a forced host cycle. Must be ≥ 1.
- `CNT_W`, 4: starvation counter width. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `core_ce_i`  in  1  core data access enable.
- `core_we_i`  in  1  core write enable.
- `core_addr_i`  in  32  core byte address.
- `core_wdata_i`  in  32  core write data.
- `core_rdata_o`  out  32  core read data; combinational from `mem_rdata_i`.
- `core_stall_o`  out  1  core must hold its current access and not advance.
- `host_req_i`  in  1  host request.
- `host_we_i`  in  1  host write enable.
- `host_addr_i`  in  32  host byte address.
- `host_wdata_i`  in  32  host write data.
- `host_gnt_o`  out  1  host access performed this cycle; combinational.
- `host_rvalid_o`  out  1  one-cycle pulse: `host_rdata_o` is valid.
- `host_rdata_o`  out  32  registered host read data.
- `mem_ce_o`, `mem_we_o`  out  1 each  to `data_mem`.
- `mem_addr_o`, `mem_wdata_o`  out  32 each  to `data_mem`.
- `mem_rdata_i`  in  32  from `data_mem`; combinational read.

## Operation
State register `st` ∈ {NORMAL, FORCE}. Starvation counter `cnt` is CNT_W bits.

Grant selection, combinational from `st` and the inputs:
- **NORMAL, `core_ce_i`=1:** core owns memory. The `mem_*` outputs mirror the core inputs. `host_gnt_o`=0.
- **NORMAL, `core_ce_i`=0 and `host_req_i`=1:** host owns memory. The `mem_*` outputs mirror the host inputs. `host_gnt_o`=1.
- **NORMAL, neither requesting:** `mem_ce_o`=0. `mem_we_o`=0.
- **FORCE:** `core_stall_o`=1 and the core is ignored. If `host_req_i`=1, the host owns memory and `host_gnt_o`=1. Otherwise `mem_ce_o`=0; this is a protocol violation, and the stall still occurs.
- **Idle buses:** when a master is not selected, `mem_addr_o` and `mem_wdata_o` carry core values.

`core_stall_o`=1 only in FORCE.

Counter, updated at each rising edge (evaluated only when `rst`=1):
- If `host_req_i` && !`host_gnt_o`: `cnt` ← min(`cnt`+1, STARVE_LIMIT).
- Otherwise: `cnt` ← 0.

State transitions:
- NORMAL→FORCE when the next `cnt` value equals STARVE_LIMIT.
- FORCE→NORMAL unconditionally after one cycle. `cnt` ← 0 on this transition.

Host protocol:
- Once `host_req_i` rises, the host holds `host_req_i`, `host_we_i`, `host_addr_i` and `host_wdata_i` stable until the cycle with `host_gnt_o`=1. That cycle completes the transfer.
- The host may issue back-to-back requests.
- On a read grant (`host_gnt_o` && !`host_we_i`): `host_rdata_o` ← `mem_rdata_i` at that edge, and `host_rvalid_o`=1 for exactly the next cycle.
- On a write grant: `host_rvalid_o` stays 0.
- `host_rdata_o` holds its value until the next host read grant.

Reset (`rst`=0 sampled at an edge):
- Next state: `st`=NORMAL, `cnt`=0, `host_rvalid_o`=0, `host_rdata_o`=0.
- While `rst`=0, `mem_ce_o`, `mem_we_o` and `host_gnt_o` are forced to 0, so no memory write can occur during reset.
- Reset in FORCE returns to NORMAL. A pending `host_rvalid_o` is dropped.

## Timing
- Host grant latency:
  - 0 cycles when the core is idle.
  - Worst case STARVE_LIMIT+1 cycles after `host_req_i` rises: STARVE_LIMIT denied cycles, then the FORCE cycle.
- Host read data: `host_rvalid_o` and `host_rdata_o` appear 1 cycle after the grant cycle.
- Core read: 0-cycle latency, unchanged from a direct connection.
- Core stall: at most 1 cycle per STARVE_LIMIT+1 cycles. `core_stall_o` is derived only from `st`, so it is glitch-free and known at cycle start.
- A core access with `core_ce_i`=1 during FORCE is not performed. The core replays it in the next cycle.

## Test plan
- **Core only:** core writes 0xDEADBEEF to 0x10, then reads 0x10 → `core_rdata_o`=0xDEADBEEF, `core_stall_o`=0 throughout, `host_gnt_o`=0.
- **Host with core idle:** host write of 0x12345678 to 0x20, then host read of 0x20 → `host_gnt_o`=1 in each request cycle, `host_rvalid_o` pulses 1 cycle after the read grant, `host_rdata_o`=0x12345678.
- **Starvation, STARVE_LIMIT=8:** `core_ce_i` held at 1 while host requests a read → 8 cycles with `host_gnt_o`=0, then cycle 9 has `core_stall_o`=1 and `host_gnt_o`=1, `host_rvalid_o`=1 in cycle 10, `cnt` returns to 0, and the core proceeds unstalled.
- **Host request withdrawn:** core busy, host holds `host_req_i` for 5 cycles, drops it for 1 cycle, then re-asserts → `cnt` clears, and FORCE occurs only after 8 further denied cycles.
- **Reset during FORCE:** `rst`=0 in the FORCE cycle → next cycle `st`=NORMAL, `core_stall_o`=0, `host_rvalid_o`=0. `mem_we_o`=0 while `rst`=0, and memory contents at the host address are unchanged.
- **Back-to-back host reads with core idle:** reads of 0x0, 0x4, 0x8 in consecutive cycles → three consecutive `host_rvalid_o` pulses with the matching data.
